rv0_wbu_i: RTL and testbench

//  Integer writeback unit. Sits directly downstream of the integer execute stage buffer.

---
 rtl/rv0_pkg.sv | 24 ++
 rtl/rv_sbuf_if.sv | 21 ++
 rtl/rv0_wbu_dec.sv | 15 +
 rtl/rv0_wbu_i.sv | 142 ++++++++++++++
 tb/tb_rv0_wbu_i.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv0_pkg.sv
// rv0 shared definitions: opcodes, writeback FSM states.
// Used by the writeback unit (optional trace: RV0_WBU_TRACE_EN).
package rv0_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {
    WBU_IDLE,
    WBU_HOLD
  } wbu_state_e;

  function automatic logic opc_writes_rd(
    input logic [6:0] opc
  );
    return opc inside {OPC_OP, OPC_OP_IMM, OPC_LUI,
                       OPC_AUIPC, OPC_JAL, OPC_JALR};
  endfunction

endpackage

// File: rtl/rv_sbuf_if.sv
// Stage-buffer handshake: producer offers an entry with rdy,
// consumer takes it in a cycle with rdy && ack.
interface rv_sbuf_if #(
  parameter int XLEN = 32
);
  logic [31:0]     insn;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] idata1;
  logic            rdy;
  logic            ack;

  modport src (
    output insn, addr, idata1, rdy,
    input  ack
  );

  modport snk (
    input  insn, addr, idata1, rdy,
    output ack
  );
endinterface

// File: rtl/rv0_wbu_dec.sv
// Writeback decode: destination register and whether the
// instruction writes the integer register file.
module rv0_wbu_dec
  import rv0_pkg::*;
(
  input  logic [11:0] insn_i,
  output logic [4:0]  rd_o,
  output logic        need_wr_o
);

  assign rd_o      = insn_i[11:7];
  assign need_wr_o = (rd_o != 5'd0) &&
                     opc_writes_rd(insn_i[6:0]);

endmodule

// File: rtl/rv0_wbu_i.sv
// Integer writeback unit: one-entry holding register, RF write
// port, retire pulse and counter. Trace ports: RV0_WBU_TRACE_EN.
module rv0_wbu_i
  import rv0_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int FLEN  = 0,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wbu_flush_i,
  rv_sbuf_if.snk           exu_sbuf_if,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  input  logic             rf_wgnt_i,
  output logic             retire_o,
  output logic [CNT_W-1:0] instret_o
`ifdef RV0_WBU_TRACE_EN
  ,
  output logic             trace_valid_o,
  output logic [XLEN-1:0]  trace_addr_o,
  output logic [31:0]      trace_insn_o,
  output logic [4:0]       trace_rd_o,
  output logic [XLEN-1:0]  trace_wdata_o
`endif
);

  if (FLEN != 0) begin : g_flen
  end

`ifdef RV0_WBU_TRACE_EN
  localparam int IW = 32;
`else
  localparam int IW = 12;
`endif

  wbu_state_e state_q, state_d;
  logic [IW-1:0]    insn_q;
  logic [XLEN-1:0]  wdata_q;
  logic             retire_q;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [4:0] rd;
  logic       need_wr;
  logic       hold;
  logic       done;
  logic       ack;
  logic       accept;

  rv0_wbu_dec u_dec (
    .insn_i    (insn_q[11:0]),
    .rd_o      (rd),
    .need_wr_o (need_wr)
  );

  assign hold = (state_q == WBU_HOLD);

  always_comb begin
    done    = hold && (!need_wr || rf_wgnt_i) &&
              !wbu_flush_i;
    ack     = (!hold || done) && !wbu_flush_i &&
              !rst_i;
    accept  = exu_sbuf_if.rdy && ack;
    state_d = state_q;
    unique case (state_q)
      WBU_IDLE: begin
        if (accept) state_d = WBU_HOLD;
      end
      WBU_HOLD: begin
        if (done) begin
          state_d = accept ? WBU_HOLD : WBU_IDLE;
        end
      end
      default: state_d = WBU_IDLE;
    endcase
    if (wbu_flush_i) state_d = WBU_IDLE;
    instret_d = instret_q + CNT_W'(done);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= WBU_IDLE;
      insn_q    <= '0;
      wdata_q   <= '0;
      retire_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        insn_q  <= exu_sbuf_if.insn[IW-1:0];
        wdata_q <= exu_sbuf_if.idata1;
      end
      retire_q  <= done;
      instret_q <= instret_d;
    end
  end

  assign exu_sbuf_if.ack = ack;
  assign rf_we_o    = hold && need_wr && !wbu_flush_i;
  assign rf_waddr_o = rd;
  assign rf_wdata_o = wdata_q;
  assign retire_o   = retire_q;
  assign instret_o  = instret_q;

`ifdef RV0_WBU_TRACE_EN
  logic [XLEN-1:0] addr_q;
  logic            tr_vld_q;
  logic [XLEN-1:0] tr_addr_q;
  logic [31:0]     tr_insn_q;
  logic [4:0]      tr_rd_q;
  logic [XLEN-1:0] tr_wdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      tr_vld_q   <= 1'b0;
      tr_addr_q  <= '0;
      tr_insn_q  <= '0;
      tr_rd_q    <= '0;
      tr_wdata_q <= '0;
    end else begin
      if (accept) addr_q <= exu_sbuf_if.addr;
      tr_vld_q <= done;
      if (done) begin
        tr_addr_q  <= addr_q;
        tr_insn_q  <= insn_q;
        tr_rd_q    <= need_wr ? rd : 5'd0;
        tr_wdata_q <= need_wr ? wdata_q : '0;
      end
    end
  end

  assign trace_valid_o = tr_vld_q;
  assign trace_addr_o  = tr_addr_q;
  assign trace_insn_o  = tr_insn_q;
  assign trace_rd_o    = tr_rd_q;
  assign trace_wdata_o = tr_wdata_q;
`endif

endmodule

// File: tb/tb_rv0_wbu_i.sv
// Directed bench for rv0_wbu_i: write scoreboard plus
// retire/counter checks. Optional trace: RV0_WBU_TRACE_EN.
module tb_rv0_wbu_i;

  logic        clk = 1'b0;
  logic        rst, flush, gnt;
  logic        we, retire;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [63:0] instret;
`ifdef RV0_WBU_TRACE_EN
  logic        tr_vld;
  logic [31:0] tr_addr, tr_insn, tr_wdata;
  logic [4:0]  tr_rd;
`endif

  always #5 clk = ~clk;

  rv_sbuf_if #(.XLEN(32)) sbuf ();

  rv0_wbu_i #(
    .XLEN  (32),
    .FLEN  (0),
    .CNT_W (64)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wbu_flush_i (flush),
    .exu_sbuf_if (sbuf),
    .rf_we_o     (we),
    .rf_waddr_o  (waddr),
    .rf_wdata_o  (wdata),
    .rf_wgnt_i   (gnt),
    .retire_o    (retire),
    .instret_o   (instret)
`ifdef RV0_WBU_TRACE_EN
    ,
    .trace_valid_o (tr_vld),
    .trace_addr_o  (tr_addr),
    .trace_insn_o  (tr_insn),
    .trace_rd_o    (tr_rd),
    .trace_wdata_o (tr_wdata)
`endif
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          ret_cnt = 0;
  logic [31:0] pc = 32'h1000;

  localparam logic [31:0] I_ADD3 = 32'h002081B3;
  localparam logic [31:0] I_ADD9 = 32'h002084B3;
  localparam logic [31:0] I_NOPX = 32'h00700013;
  localparam logic [31:0] I_SW   = 32'h00112023;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(
    input logic [4:0] rd,
    input logic [11:0] imm
  );
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic drive(input logic [31:0] insn,
                       input logic [31:0] data,
                       input bit exp_wr);
    wr_t e;
    sbuf.rdy    = 1'b1;
    sbuf.insn   = insn;
    sbuf.idata1 = data;
    sbuf.addr   = pc;
    pc          = pc + 32'd4;
    if (exp_wr) begin
      e.rd   = insn[11:7];
      e.data = data;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (retire === 1'b1) ret_cnt++;
    if (!rst && we === 1'b1 && gnt) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", {59'd0, waddr}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", {59'd0, waddr}, {59'd0, e.rd});
        chk("wr_data", {32'd0, wdata}, {32'd0, e.data});
      end
    end
  end

  initial begin
    int w0, r0;
    rst         = 1'b1;
    flush       = 1'b0;
    gnt         = 1'b0;
    sbuf.rdy    = 1'b0;
    sbuf.insn   = '0;
    sbuf.idata1 = '0;
    sbuf.addr   = '0;

    // reset state
    repeat (2) tick();
    chk("rst_we", {63'd0, we}, 64'd0);
    chk("rst_waddr", {59'd0, waddr}, 64'd0);
    chk("rst_wdata", {32'd0, wdata}, 64'd0);
    chk("rst_retire", {63'd0, retire}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_ack", {63'd0, sbuf.ack}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: back-to-back ADDI x5
    gnt = 1'b1;
    w0 = wr_cnt;
    r0 = ret_cnt;
    for (int k = 1; k <= 4; k++) begin
      drive(addi(5'd5, 12'(k)), 32'(k), 1'b1);
      #1;
      chk("t1_ack", {63'd0, sbuf.ack}, 64'd1);
      if (k > 1) chk("t1_we", {63'd0, we}, 64'd1);
      tick();
    end
    sbuf.rdy = 1'b0;
    #1;
    chk("t1_we_last", {63'd0, we}, 64'd1);
    tick();
    tick();
    chk("t1_wr", 64'(wr_cnt - w0), 64'd4);
    chk("t1_ret", 64'(ret_cnt - r0), 64'd4);
    chk("t1_instret", instret, 64'd4);

    // 2: no-write instructions
    w0 = wr_cnt;
    r0 = ret_cnt;
    drive(I_NOPX, 32'd7, 1'b0);
    tick();
    drive(I_SW, 32'h1234, 1'b0);
    #1;
    chk("t2_we0", {63'd0, we}, 64'd0);
    tick();
    sbuf.rdy = 1'b0;
    #1;
    chk("t2_we1", {63'd0, we}, 64'd0);
    tick();
    tick();
    chk("t2_wr", 64'(wr_cnt - w0), 64'd0);
    chk("t2_ret", 64'(ret_cnt - r0), 64'd2);
    chk("t2_instret", instret, 64'd6);

    // 3: grant stall with a waiting entry
    gnt = 1'b0;
    drive(I_ADD3, 32'hDEADBEEF, 1'b1);
    tick();
    drive(addi(5'd6, 12'd9), 32'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_ack", {63'd0, sbuf.ack}, 64'd0);
      chk("t3_we", {63'd0, we}, 64'd1);
      chk("t3_waddr", {59'd0, waddr}, 64'd3);
      chk("t3_wdata", {32'd0, wdata}, 64'hDEADBEEF);
      chk("t3_noret", {63'd0, retire}, 64'd0);
      tick();
    end
    gnt = 1'b1;
    #1;
    chk("t3_ack_gnt", {63'd0, sbuf.ack}, 64'd1);
    tick();
    sbuf.rdy = 1'b0;
    #1;
    chk("t3_ret", {63'd0, retire}, 64'd1);
    chk("t3_next", {59'd0, waddr}, 64'd6);
    tick();
    tick();
    chk("t3_instret", instret, 64'd8);

    // 4: flush while holding
    drive(addi(5'd7, 12'h055), 32'h55, 1'b0);
    tick();
    sbuf.rdy = 1'b0;
    flush    = 1'b1;
    #1;
    chk("t4_we", {63'd0, we}, 64'd0);
    chk("t4_ack", {63'd0, sbuf.ack}, 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("t4_idle_ack", {63'd0, sbuf.ack}, 64'd1);
    chk("t4_idle_we", {63'd0, we}, 64'd0);
    tick();
    chk("t4_noret", {63'd0, retire}, 64'd0);
    chk("t4_instret", instret, 64'd8);

    // 5: counter wrap
    force dut.instret_q = '1;
    #1;
    release dut.instret_q;
    #1;
    chk("t5_preset", instret, '1);
    drive(addi(5'd8, 12'd3), 32'd3, 1'b1);
    tick();
    sbuf.rdy = 1'b0;
    tick();
    #1;
    chk("t5_ret", {63'd0, retire}, 64'd1);
    chk("t5_wrap", instret, 64'd0);

    // 6: reset during HOLD with grant pending
    gnt = 1'b0;
    drive(I_ADD9, 32'hAAAA, 1'b0);
    tick();
    sbuf.rdy = 1'b0;
    rst      = 1'b1;
    #1;
    chk("t6_pend", {63'd0, we}, 64'd1);
    tick();
    #1;
    chk("t6_we", {63'd0, we}, 64'd0);
    chk("t6_waddr", {59'd0, waddr}, 64'd0);
    chk("t6_wdata", {32'd0, wdata}, 64'd0);
    chk("t6_retire", {63'd0, retire}, 64'd0);
    chk("t6_instret", instret, 64'd0);
    chk("t6_ack", {63'd0, sbuf.ack}, 64'd0);
    rst = 1'b0;
    gnt = 1'b1;
    drive(addi(5'd10, 12'h033), 32'h33, 1'b1);
    #1;
    chk("t6_ack_new", {63'd0, sbuf.ack}, 64'd1);
    tick();
    sbuf.rdy = 1'b0;
    tick();
    #1;
    chk("t6_ret", {63'd0, retire}, 64'd1);
    chk("t6_instret1", instret, 64'd1);
    tick();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
